// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_responder
// Brief   : Round-robin multi-channel memory responder on one single-ported
//           array. Writes are served only when DATA_MEM_RESP_WRITE_EN is set.
// Rev     : 1.0  initial release
// ============================================================================
module data_mem_responder #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8,
    parameter int CHANNELS  = 4,
    parameter int LATENCY   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [CHANNELS-1:0]            mem_read_valid,
    input  logic [CHANNELS*ADDR_BITS-1:0]  mem_read_address,
    output logic [CHANNELS-1:0]            mem_read_ready,
    output logic [CHANNELS*DATA_BITS-1:0]  mem_read_data,
    input  logic [CHANNELS-1:0]            mem_write_valid,
    input  logic [CHANNELS*ADDR_BITS-1:0]  mem_write_address,
    input  logic [CHANNELS*DATA_BITS-1:0]  mem_write_data,
    output logic [CHANNELS-1:0]            mem_write_ready,
    input  logic                           load_en,
    input  logic [ADDR_BITS-1:0]           load_addr,
    input  logic [DATA_BITS-1:0]           load_data
);

    localparam int c_CH_BITS  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int c_CNT_BITS = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int c_DEPTH    = 1 << ADDR_BITS;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_BUSY = 2'd1;
    localparam logic [1:0] c_S_RESP = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [c_CH_BITS-1:0]  r_rr;
    logic [c_CH_BITS-1:0]  r_ch;
    logic [c_CH_BITS-1:0]  w_grant_ch;
    logic [c_CH_BITS-1:0]  w_rr_next;
    logic [c_CNT_BITS-1:0] r_cnt;
    logic [ADDR_BITS-1:0]  r_addr;
    logic [ADDR_BITS-1:0]  w_sel_addr;
    logic [DATA_BITS-1:0]  r_mem [c_DEPTH];
    logic [DATA_BITS-1:0]  w_mem_rdata;
    logic [DATA_BITS-1:0]  r_rdata [CHANNELS];
    logic [ADDR_BITS-1:0]  w_rd_addr [CHANNELS];
    logic [CHANNELS-1:0]   w_wr_valid;
    logic [CHANNELS-1:0]   w_eligible;
    logic                  w_any;
    logic                  w_grant;
    logic                  w_commit;
    logic                  w_commit_read;
    int                    w_idx;

`ifdef DATA_MEM_RESP_WRITE_EN
    logic                  r_is_write;
    logic [DATA_BITS-1:0]  r_wdata;
    logic                  w_grant_is_write;
    logic [ADDR_BITS-1:0]  w_wr_addr [CHANNELS];
    logic [DATA_BITS-1:0]  w_wr_data [CHANNELS];

    assign w_wr_valid = mem_write_valid;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_wr_ch
        assign w_wr_addr[c] = mem_write_address[c*ADDR_BITS +: ADDR_BITS];
        assign w_wr_data[c] = mem_write_data[c*DATA_BITS +: DATA_BITS];
    end

    // A channel with both valids is served as a read; its write waits for a later grant.
    assign w_grant_is_write = !mem_read_valid[w_grant_ch];
    assign w_sel_addr       = w_grant_is_write ? w_wr_addr[w_grant_ch] : w_rd_addr[w_grant_ch];
    assign w_commit_read    = w_commit && !r_is_write;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_is_write <= 1'b0;
            r_wdata    <= '0;
        end else if (w_grant) begin
            r_is_write <= w_grant_is_write;
            r_wdata    <= w_wr_data[w_grant_ch];
        end
    end
`else
    logic w_unused_write;

    assign w_wr_valid     = '0;
    assign w_sel_addr     = w_rd_addr[w_grant_ch];
    assign w_commit_read  = w_commit;
    assign w_unused_write = ^{mem_write_valid, mem_write_address, mem_write_data};
`endif

    assign w_eligible = mem_read_valid | w_wr_valid;

    // Round-robin search starting at r_rr; walking backwards lets the nearest hit win.
    always_comb begin
        w_any      = 1'b0;
        w_grant_ch = '0;
        w_idx      = 0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            w_idx = int'(r_rr) + i;
            if (w_idx >= CHANNELS) begin
                w_idx = w_idx - CHANNELS;
            end
            if (w_eligible[c_CH_BITS'(w_idx)]) begin
                w_any      = 1'b1;
                w_grant_ch = c_CH_BITS'(w_idx);
            end
        end
    end

    assign w_rr_next = (w_grant_ch == c_CH_BITS'(CHANNELS - 1)) ? '0
                                                                : w_grant_ch + c_CH_BITS'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_S_IDLE: if (w_any) w_next_state = c_S_BUSY;
            c_S_BUSY: if (r_cnt == '0) w_next_state = c_S_RESP;
            c_S_RESP: w_next_state = c_S_IDLE;
            default:  w_next_state = c_S_IDLE;
        endcase
    end

    // Commit is suppressed on a reset edge so an aborted write never lands.
    always_comb begin
        w_grant         = 1'b0;
        w_commit        = 1'b0;
        mem_read_ready  = '0;
        mem_write_ready = '0;
        case (r_state)
            c_S_IDLE: w_grant  = w_any;
            c_S_BUSY: w_commit = (r_cnt == '0) && reset;
            c_S_RESP: begin
`ifdef DATA_MEM_RESP_WRITE_EN
                if (r_is_write) mem_write_ready[r_ch] = 1'b1;
                else
`endif
                mem_read_ready[r_ch] = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rr   <= '0;
            r_cnt  <= '0;
            r_ch   <= '0;
            r_addr <= '0;
        end else if (w_grant) begin
            r_rr   <= w_rr_next;
            r_cnt  <= c_CNT_BITS'(LATENCY - 1);
            r_ch   <= w_grant_ch;
            r_addr <= w_sel_addr;
        end else if (r_state == c_S_BUSY && r_cnt != '0) begin
            r_cnt  <= r_cnt - c_CNT_BITS'(1);
        end
    end

    // Storage has no reset; the load port is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
`ifdef DATA_MEM_RESP_WRITE_EN
        if (w_commit && r_is_write) begin
            r_mem[r_addr] <= r_wdata;
        end
`endif
        if (load_en) begin
            r_mem[load_addr] <= load_data;
        end
    end

    assign w_mem_rdata = r_mem[r_addr];

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        assign w_rd_addr[c] = mem_read_address[c*ADDR_BITS +: ADDR_BITS];
        assign mem_read_data[c*DATA_BITS +: DATA_BITS] = r_rdata[c];

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_rdata[c] <= '0;
            end else if (w_commit_read && r_ch == c_CH_BITS'(c)) begin
                r_rdata[c] <= w_mem_rdata;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_responder
// Brief   : Directed and randomized checks of data_mem_responder against a
//           transaction-level model (memory array plus round-robin pointer).
// Rev     : 1.0  initial release
// ============================================================================
module tb_data_mem_responder;

    localparam int AB  = 8;
    localparam int DB  = 8;
    localparam int CH  = 4;
    localparam int LAT = 2;
`ifdef DATA_MEM_RESP_WRITE_EN
    localparam bit WR_EN = 1'b1;
`else
    localparam bit WR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [CH-1:0]    rv;
    logic [CH*AB-1:0] ra;
    logic [CH-1:0]    rr_o;
    logic [CH*DB-1:0] rd_o;
    logic [CH-1:0]    wv;
    logic [CH*AB-1:0] wa;
    logic [CH*DB-1:0] wd;
    logic [CH-1:0]    wr_o;
    logic             load_en;
    logic [AB-1:0]    load_addr;
    logic [DB-1:0]    load_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DB-1:0] mdl_mem   [2**AB];
    logic [DB-1:0] mdl_rdata [CH];
    int            mdl_rr;

    always #5 clk = ~clk;

    data_mem_responder #(
        .ADDR_BITS(AB), .DATA_BITS(DB), .CHANNELS(CH), .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mem_read_valid(rv),
        .mem_read_address(ra),
        .mem_read_ready(rr_o),
        .mem_read_data(rd_o),
        .mem_write_valid(wv),
        .mem_write_address(wa),
        .mem_write_data(wd),
        .mem_write_ready(wr_o),
        .load_en(load_en),
        .load_addr(load_addr),
        .load_data(load_data)
    );

    initial begin
        #800000;
        $display("FAIL watchdog: observed no completion, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [AB-1:0] a, input logic [DB-1:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en   = 1'b0;
        mdl_mem[a] = d;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        rv = '0;
        wv = '0;
        tick();
        tick();
        reset  = 1'b1;
        mdl_rr = 0;
        for (int c = 0; c < CH; c++) mdl_rdata[c] = '0;
    endtask

    function automatic int pick(input logic [CH-1:0] mask);
        for (int i = 0; i < CH; i++) begin
            if (mask[(mdl_rr + i) % CH]) return (mdl_rr + i) % CH;
        end
        return -1;
    endfunction

    function automatic logic [CH*DB-1:0] model_rdata();
        logic [CH*DB-1:0] v;
        for (int c = 0; c < CH; c++) v[c*DB +: DB] = mdl_rdata[c];
        return v;
    endfunction

    // Serves every pending request, checking order, latency, data and pulse width.
    task automatic serve(input logic [CH-1:0] prd_in, input logic [CH-1:0] pwr_in);
        logic [CH-1:0] prd, pwr, onehot;
        int            c, cyc;
        bit            is_wr;
        prd = prd_in;
        pwr = WR_EN ? pwr_in : '0;
        while ((prd | pwr) != '0) begin
            c      = pick(prd | pwr);
            is_wr  = !prd[c];
            onehot = '0;
            onehot[c] = 1'b1;
            cyc = 0;
            while (rr_o == '0 && wr_o == '0 && cyc < 64) begin
                tick();
                cyc++;
            end
            chk("latency", cyc, LAT + 1);
            if (cyc >= 64) begin
                rv = '0;
                wv = '0;
                return;
            end
            chk("read_ready", rr_o, is_wr ? '0 : onehot);
            chk("write_ready", wr_o, is_wr ? onehot : '0);
            if (is_wr) mdl_mem[wa[c*AB +: AB]] = wd[c*DB +: DB];
            else       mdl_rdata[c] = mdl_mem[ra[c*AB +: AB]];
            mdl_rr = (c + 1) % CH;
            chk("read_data", rd_o, model_rdata());
            if (is_wr) begin
                wv[c]  = 1'b0;
                pwr[c] = 1'b0;
            end else begin
                rv[c]  = 1'b0;
                prd[c] = 1'b0;
                if (!WR_EN) wv[c] = 1'b0;
            end
            tick();
            chk("pulse_width", {rr_o, wr_o}, '0);
        end
    endtask

    task automatic req(input int c, input bit r, input bit w, input logic [AB-1:0] a,
                       input logic [DB-1:0] d);
        logic [CH-1:0] m;
        m = '0;
        m[c] = 1'b1;
        ra[c*AB +: AB] = a;
        wa[c*AB +: AB] = a;
        wd[c*DB +: DB] = d;
        rv[c] = r;
        wv[c] = w;
        serve(r ? m : '0, w ? m : '0);
    endtask

    initial begin
        logic [CH-1:0] mask, prd, pwr;
        bit            r, w;

        reset = 1'b0;
        rv = '0; ra = '0; wv = '0; wa = '0; wd = '0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        mdl_rr = 0;
        for (int c = 0; c < CH; c++) mdl_rdata[c] = '0;
        repeat (3) tick();
        reset = 1'b1;

        chk("reset_read_ready", rr_o, '0);
        chk("reset_write_ready", wr_o, '0);
        chk("reset_read_data", rd_o, '0);

        for (int a = 0; a < 2**AB; a++) do_load(AB'(a), DB'($urandom));

        do_load(8'd5, 8'h2A);
        req(0, 1'b1, 1'b0, 8'd5, 8'h00);
        chk("read_addr5", rd_o[0 +: DB], 8'h2A);

`ifdef DATA_MEM_RESP_WRITE_EN
        req(1, 1'b0, 1'b1, 8'd16, 8'h77);
        req(1, 1'b1, 1'b0, 8'd16, 8'h00);
        chk("write_then_read", rd_o[DB +: DB], 8'h77);

        // Read and write together on channel 2: read must complete first.
        ra[2*AB +: AB] = 8'd16;
        wa[2*AB +: AB] = 8'd20;
        wd[2*DB +: DB] = 8'hE1;
        rv[2] = 1'b1;
        wv[2] = 1'b1;
        serve(4'b0100, 4'b0100);

        // Load collides with a write commit to the same address; load wins.
        do_load(8'd40, 8'h01);
        wa[3*AB +: AB] = 8'd40;
        wd[3*DB +: DB] = 8'hAA;
        wv[3] = 1'b1;
        repeat (LAT) tick();
        load_en = 1'b1; load_addr = 8'd40; load_data = 8'hBB;
        tick();
        load_en = 1'b0;
        chk("collide_write_ready", wr_o, 4'b1000);
        wv[3] = 1'b0;
        mdl_mem[40] = 8'hBB;
        mdl_rr = 0;
        tick();
        req(3, 1'b1, 1'b0, 8'd40, 8'h00);
        chk("collide_load_wins", rd_o[3*DB +: DB], 8'hBB);

        // Reset during BUSY of a write discards it.
        do_load(8'd3, 8'h11);
        wa[0 +: AB] = 8'd3;
        wd[0 +: DB] = 8'h55;
        wv[0] = 1'b1;
        tick();
        reset = 1'b0;
        wv[0] = 1'b0;
        tick();
        reset = 1'b1;
        mdl_rr = 0;
        for (int c = 0; c < CH; c++) mdl_rdata[c] = '0;
        chk("abort_read_data", rd_o, '0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_ready", {rr_o, wr_o}, '0);
        end
        req(0, 1'b1, 1'b0, 8'd3, 8'h00);
        chk("abort_storage", rd_o[0 +: DB], 8'h11);
`else
        // Read-only build: write requests are ignored entirely.
        do_load(8'd9, 8'h3C);
        wa[0 +: AB] = 8'd9;
        wd[0 +: DB] = 8'hC3;
        wv[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("ro_no_ready", {rr_o, wr_o}, '0);
        end
        wv[0] = 1'b0;
        req(0, 1'b1, 1'b0, 8'd9, 8'h00);
        chk("ro_storage", rd_o[0 +: DB], 8'h3C);
`endif

        // All four channels at once right after reset: order 0,1,2,3.
        do_reset();
        for (int c = 0; c < CH; c++) ra[c*AB +: AB] = AB'($urandom);
        rv = '1;
        serve('1, '0);
        chk("rr_wrapped", mdl_rr, 0);
        rv = '1;
        serve('1, '0);

        for (int it = 0; it < 20; it++) begin
            mask = CH'($urandom_range(1, 2**CH - 1));
            prd = '0;
            pwr = '0;
            for (int c = 0; c < CH; c++) begin
                if (mask[c]) begin
                    r = 1'($urandom);
                    w = WR_EN ? 1'($urandom) : 1'b0;
                    if (!r && !w) r = 1'b1;
                    ra[c*AB +: AB] = AB'($urandom_range(0, 31));
                    wa[c*AB +: AB] = AB'($urandom_range(0, 31));
                    wd[c*DB +: DB] = DB'($urandom);
                    rv[c] = r;
                    wv[c] = WR_EN ? w : 1'($urandom);
                    prd[c] = r;
                    pwr[c] = w;
                end
            end
            serve(prd, pwr);
            if ($urandom_range(0, 1) == 1) do_load(AB'($urandom_range(0, 31)), DB'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
